pc_trace_unit: RTL and testbench
================================

# pc_trace_unit

Synthesizable commit-trace recorder that sits directly downstream of the SOPC and consumes its PC and ID-stage instruction stream. It replaces the simulation-only `$monitor` with a hardware FIFO of (PC, instruction) pairs, so the same check works on FPGA and in the bench. It records one entry per PC change, drains entries over a valid/ready port, and flags program completion when the PC stops moving.

## Interface
- `DEPTH`, 16: FIFO entries. Must be a power of two, ≥ 2.
- `ADDR_W`, 4: log2(`DEPTH`).
- `HALT_CYCLES`, 8: consecutive stalled-PC cycles that declare halt. Must be ≥ 2.

- `clk`: in, 1. Single clock, rising edge.
- `rstn`: in, 1. Synchronous, active-low reset.
- `en_i`: in, 1. Capture enable.
- `pc_i`: in, 32. SOPC PC.
- `instr_i`: in, 32. SOPC ID-stage instruction.
- `rd_valid_o`: out, 1. FIFO head is valid.
- `rd_ready_i`: in, 1. Consumer accepts the head.
- `rd_pc_o`: out, 32. Head PC.
- `rd_instr_o`: out, 32. Head instruction.
- `count_o`: out, `ADDR_W`+1. Number of occupied entries.
- `overflow_o`: out, 1. Sticky: at least one entry was dropped.
- `drop_cnt_o`: out, 16. Dropped entries. Saturates at 0xFFFF.
- `halted_o`: out, 1. Halt detected.

## Operation
- **States:** IDLE, ARMED, RUN, HALTED. Reset enters IDLE.
- **IDLE:**
  - Nothing is captured.
  - `en_i`=1 moves to ARMED.
- **ARMED:**
  - The first sampled cycle always captures (`pc_i`, `instr_i`), loads `last_pc` with `pc_i`, clears the stall counter, and moves to RUN.
  - `en_i`=0 moves to IDLE.
- **RUN:**
  - If `pc_i` ≠ `last_pc`: capture the pair, update `last_pc`, clear the stall counter.
  - Otherwise: increment the stall counter.
  - When the counter reaches `HALT_CYCLES`−1 on a stalled cycle, move to HALTED.
  - `en_i`=0 moves to IDLE. `last_pc` and the stall counter are discarded; re-enable passes through ARMED.
- **HALTED:**
  - `halted_o`=1. No captures.
  - Leave only via `en_i`=0 (to IDLE, which clears `halted_o`) or via reset.
- **Capture → FIFO write rules:**
  - The write is accepted if `count_o` < `DEPTH`, or if a pop happens in the same cycle.
  - Otherwise the entry is dropped: `overflow_o` is set, and `drop_cnt_o` increments, saturating.
  - A dropped capture still updates `last_pc`.
- **Read port:**
  - A pop happens when `rd_valid_o` && `rd_ready_i`.
  - `rd_valid_o` = (`count_o` ≠ 0).
  - Head data is first-word-fall-through, driven from the storage array at the read pointer.
  - `rd_ready_i` with an empty FIFO is a no-op.
- **Pointers:**
  - Read and write pointers are `ADDR_W` bits and wrap modulo `DEPTH`.
  - `count_o` is tracked separately: +1 on write only, −1 on pop only, unchanged on both.
- FIFO contents, `count_o`, `overflow_o` and `drop_cnt_o` are retained across IDLE. Only reset clears them.

## Timing
- **Reset values:**
  - `rd_valid_o`=0, `rd_pc_o`=0, `rd_instr_o`=0, `count_o`=0.
  - `overflow_o`=0, `drop_cnt_o`=0, `halted_o`=0.
  - State=IDLE, pointers=0, `last_pc`=0.
- **Reset mid-operation:** a cycle with `rstn`=0 discards all entries, regardless of pending reads or writes.
- **Capture latency:** a pair sampled at edge N appears at the head (if the FIFO was empty) with `rd_valid_o`=1 after edge N, i.e. usable in cycle N+1.
- **Pop:** takes effect at the edge. The next entry is visible in the following cycle.
- **Full FIFO + simultaneous pop + capture:** both happen, `count_o` stays at `DEPTH`, no drop.
- **Empty FIFO + capture + `rd_ready_i`=1 in the same cycle:** no pop, because `rd_valid_o` was 0 that cycle. The entry appears next cycle.
- **Halt timing:** after the last PC change at edge N, `halted_o` rises after edge N+`HALT_CYCLES`−1 if `pc_i` stays constant.
- **Enable timing:** `en_i` takes effect at the edge where it is sampled. There is no capture on the edge that samples `en_i`=0.

## Test plan
- **Basic stream:** reset, `en_i`=1, `pc_i` = 0x0, 0x4, 0x8, 0xC, each held 1 cycle, `rd_ready_i`=0 → `count_o`=4. Then drain with `rd_ready_i`=1 → heads 0x0, 0x4, 0x8, 0xC in order with matching instructions, then `rd_valid_o`=0.
- **Stall dedupe and halt:** `pc_i`=0x10 for 3 cycles, then 0x14 held constant, `HALT_CYCLES`=8 → 2 entries. `halted_o` rises 7 edges after 0x14 is captured. Further `pc_i` changes are not recorded.
- **Overflow:** `DEPTH`=16, 20 distinct PCs, no reads → `count_o`=16, `overflow_o`=1, `drop_cnt_o`=4. The drained head sequence is the first 16 PCs.
- **Full with concurrent pop:** FIFO full, a new PC arrives with `rd_ready_i`=1 → `count_o` stays 16, `drop_cnt_o` unchanged, the new PC is the tail.
- **Wrap-around:** push 12, pop 10, push 12 → pointers wrap, `count_o`=14, order preserved across the wrap.
- **Enable/reset mid-run:** `en_i`=0 in RUN → IDLE, contents kept. Re-enable with an unchanged PC → captured again, because ARMED always captures. Then `rstn`=0 for one cycle with `rd_ready_i`=1 → all outputs are at their reset values next cycle.

Source files
------------

// File: rtl/pc_trace_unit.sv
// Commit-trace recorder: captures (pc, instr) on every PC change into a first-word-fall-through FIFO.
// Halt is flagged once the PC has sat still for HALT_CYCLES consecutive cycles.
module pc_trace_unit #(
    parameter int DEPTH       = 16,
    parameter int ADDR_W      = 4,
    parameter int HALT_CYCLES = 8
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              en_i,
    input  logic [31:0]       pc_i,
    input  logic [31:0]       instr_i,
    output logic              rd_valid_o,
    input  logic              rd_ready_i,
    output logic [31:0]       rd_pc_o,
    output logic [31:0]       rd_instr_o,
    output logic [ADDR_W:0]   count_o,
    output logic              overflow_o,
    output logic [15:0]       drop_cnt_o,
    output logic              halted_o
);

    // state  | meaning
    // IDLE   | capture disabled, FIFO contents retained
    // ARMED  | next enabled cycle captures unconditionally and seeds last_pc
    // RUN    | capture on every PC change, count stalled cycles otherwise
    // HALTED | PC stationary long enough; nothing captured until en_i drops
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARMED  = 2'd1,
        RUN    = 2'd2,
        HALTED = 2'd3
    } state_t;

    localparam int STALL_W = $clog2(HALT_CYCLES);
    localparam logic [STALL_W-1:0] STALL_TRIP = STALL_W'(HALT_CYCLES - 2);
    localparam logic [ADDR_W:0]    FULL_CNT   = (ADDR_W+1)'(DEPTH);

    state_t               state;
    logic [31:0]          last_pc;
    logic [STALL_W-1:0]   stall_cnt;

    logic [31:0]          mem_pc    [DEPTH];
    logic [31:0]          mem_instr [DEPTH];
    logic [ADDR_W-1:0]    wptr;
    logic [ADDR_W-1:0]    rptr;
    logic [ADDR_W:0]      count;
    logic                 overflow;
    logic [15:0]          drop_cnt;
    logic                 halted;

    logic                 capture;
    logic                 pop;
    logic                 full;
    logic                 wr_ok;
    logic                 drop;

    always_comb begin
        capture = 1'b0;
        if (en_i) begin
            if (state == ARMED)
                capture = 1'b1;
            else if (state == RUN && pc_i != last_pc)
                capture = 1'b1;
        end
    end

    assign full  = (count == FULL_CNT);
    assign pop   = (count != '0) && rd_ready_i;
    // A same-cycle pop frees the slot, so a full FIFO still accepts the write.
    assign wr_ok = capture && (!full || pop);
    assign drop  = capture && !wr_ok;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state     <= IDLE;
            last_pc   <= '0;
            stall_cnt <= '0;
            halted    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (en_i)
                        state <= ARMED;
                end
                ARMED: begin
                    if (!en_i) begin
                        state <= IDLE;
                    end else begin
                        last_pc   <= pc_i;
                        stall_cnt <= '0;
                        state     <= RUN;
                    end
                end
                RUN: begin
                    if (!en_i) begin
                        state     <= IDLE;
                        last_pc   <= '0;
                        stall_cnt <= '0;
                    end else if (pc_i != last_pc) begin
                        last_pc   <= pc_i;
                        stall_cnt <= '0;
                    end else if (stall_cnt == STALL_TRIP) begin
                        state  <= HALTED;
                        halted <= 1'b1;
                    end else begin
                        stall_cnt <= stall_cnt + STALL_W'(1);
                    end
                end
                HALTED: begin
                    if (!en_i) begin
                        state     <= IDLE;
                        halted    <= 1'b0;
                        last_pc   <= '0;
                        stall_cnt <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rstn && wr_ok) begin
            mem_pc[wptr]    <= pc_i;
            mem_instr[wptr] <= instr_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else begin
            if (wr_ok)
                wptr <= wptr + ADDR_W'(1);
            if (pop)
                rptr <= rptr + ADDR_W'(1);
            case ({wr_ok, pop})
                2'b10:   count <= count + (ADDR_W+1)'(1);
                2'b01:   count <= count - (ADDR_W+1)'(1);
                default: count <= count;
            endcase
            if (drop) begin
                overflow <= 1'b1;
                if (drop_cnt != 16'hFFFF)
                    drop_cnt <= drop_cnt + 16'd1;
            end
        end
    end

    // Head data is masked while empty so stale storage never leaks out.
    assign rd_valid_o = (count != '0);
    assign rd_pc_o    = rd_valid_o ? mem_pc[rptr]    : 32'd0;
    assign rd_instr_o = rd_valid_o ? mem_instr[rptr] : 32'd0;
    assign count_o    = count;
    assign overflow_o = overflow;
    assign drop_cnt_o = drop_cnt;
    assign halted_o   = halted;

endmodule

// File: tb/tb_pc_trace_unit.sv
// Bench for pc_trace_unit: directed scenarios plus randomized traffic, all checked
// each cycle against a queue-based reference model of the trace recorder.
module tb_pc_trace_unit;

    localparam int DEPTH       = 16;
    localparam int ADDR_W      = 4;
    localparam int HALT_CYCLES = 8;

    logic              clk;
    logic              rstn;
    logic              en_i;
    logic [31:0]       pc_i;
    logic [31:0]       instr_i;
    logic              rd_valid_o;
    logic              rd_ready_i;
    logic [31:0]       rd_pc_o;
    logic [31:0]       rd_instr_o;
    logic [ADDR_W:0]   count_o;
    logic              overflow_o;
    logic [15:0]       drop_cnt_o;
    logic              halted_o;

    pc_trace_unit #(
        .DEPTH       (DEPTH),
        .ADDR_W      (ADDR_W),
        .HALT_CYCLES (HALT_CYCLES)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .en_i       (en_i),
        .pc_i       (pc_i),
        .instr_i    (instr_i),
        .rd_valid_o (rd_valid_o),
        .rd_ready_i (rd_ready_i),
        .rd_pc_o    (rd_pc_o),
        .rd_instr_o (rd_instr_o),
        .count_o    (count_o),
        .overflow_o (overflow_o),
        .drop_cnt_o (drop_cnt_o),
        .halted_o   (halted_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    bit chk_on = 1'b0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: trace as a queue, enable history as a few flags.
    logic [63:0] m_q[$];
    bit          m_armed  = 1'b0;
    bit          m_track  = 1'b0;
    bit          m_halted = 1'b0;
    bit          m_ovf    = 1'b0;
    logic [31:0] m_last   = '0;
    int          m_same   = 0;
    int          m_drop   = 0;

    always @(posedge clk) begin : model
        bit pop_m;
        bit cap_m;
        if (!rstn) begin
            m_q.delete();
            m_armed  = 1'b0;
            m_track  = 1'b0;
            m_halted = 1'b0;
            m_ovf    = 1'b0;
            m_last   = '0;
            m_same   = 0;
            m_drop   = 0;
        end else begin
            pop_m = (m_q.size() != 0) && rd_ready_i;
            cap_m = 1'b0;
            if (!en_i) begin
                m_armed  = 1'b0;
                m_track  = 1'b0;
                m_halted = 1'b0;
            end else if (m_halted) begin
                cap_m = 1'b0;
            end else if (m_track) begin
                if (pc_i != m_last) begin
                    cap_m  = 1'b1;
                    m_last = pc_i;
                    m_same = 0;
                end else begin
                    m_same++;
                    if (m_same == HALT_CYCLES - 1)
                        m_halted = 1'b1;
                end
            end else if (m_armed) begin
                cap_m   = 1'b1;
                m_last  = pc_i;
                m_same  = 0;
                m_track = 1'b1;
            end else begin
                m_armed = 1'b1;
            end
            if (pop_m)
                void'(m_q.pop_front());
            if (cap_m) begin
                if (m_q.size() < DEPTH) begin
                    m_q.push_back({pc_i, instr_i});
                end else begin
                    m_ovf = 1'b1;
                    if (m_drop < 65535)
                        m_drop++;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            logic [63:0] head;
            head = (m_q.size() != 0) ? m_q[0] : 64'd0;
            check("valid",    64'(rd_valid_o), 64'(m_q.size() != 0));
            check("head_pc",  64'(rd_pc_o),    64'(head[63:32]));
            check("head_ins", 64'(rd_instr_o), 64'(head[31:0]));
            check("count",    64'(count_o),    64'(m_q.size()));
            check("overflow", 64'(overflow_o), 64'(m_ovf));
            check("drop_cnt", 64'(drop_cnt_o), 64'(m_drop));
            check("halted",   64'(halted_o),   64'(m_halted));
        end
    end

    function automatic logic [31:0] ins(input logic [31:0] pc);
        return (pc * 32'd3) ^ 32'hA5A5_1357;
    endfunction

    task automatic tick(input bit r, input bit e, input logic [31:0] pc, input bit rdy);
        rstn       = r;
        en_i       = e;
        pc_i       = pc;
        instr_i    = ins(pc);
        rd_ready_i = rdy;
        @(negedge clk);
    endtask

    task automatic do_reset();
        tick(1'b0, 1'b0, 32'd0, 1'b0);
        tick(1'b0, 1'b0, 32'd0, 1'b0);
    endtask

    task automatic drain_check(input string nm, input logic [31:0] exp_pc);
        check({nm, "_pc"},  64'(rd_pc_o),    64'(exp_pc));
        check({nm, "_ins"}, 64'(rd_instr_o), 64'(ins(exp_pc)));
        tick(1'b1, 1'b0, 32'd0, 1'b1);
    endtask

    initial begin
        logic [31:0] rpc;
        rstn = 1'b0; en_i = 1'b0; pc_i = '0; instr_i = '0; rd_ready_i = 1'b0;
        @(negedge clk);
        do_reset();
        chk_on = 1'b1;
        check("rst_valid", 64'(rd_valid_o), 64'd0);
        check("rst_count", 64'(count_o),    64'd0);
        check("rst_pc",    64'(rd_pc_o),    64'd0);

        // basic stream
        tick(1'b1, 1'b1, 32'h0, 1'b0);
        for (int i = 0; i < 4; i++) tick(1'b1, 1'b1, 32'(i * 4), 1'b0);
        check("basic_count", 64'(count_o), 64'd4);
        tick(1'b1, 1'b0, 32'hC, 1'b0);
        for (int i = 0; i < 4; i++) drain_check("basic", 32'(i * 4));
        check("basic_empty", 64'(rd_valid_o), 64'd0);

        // stall dedupe and halt timing
        do_reset();
        tick(1'b1, 1'b1, 32'h10, 1'b0);
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b1, 32'h10, 1'b0);
        tick(1'b1, 1'b1, 32'h14, 1'b0);
        for (int i = 0; i < HALT_CYCLES - 2; i++) tick(1'b1, 1'b1, 32'h14, 1'b0);
        check("halt_early", 64'(halted_o), 64'd0);
        tick(1'b1, 1'b1, 32'h14, 1'b0);
        check("halt_rise", 64'(halted_o), 64'd1);
        tick(1'b1, 1'b1, 32'h18, 1'b0);
        tick(1'b1, 1'b1, 32'h1C, 1'b0);
        check("halt_count", 64'(count_o), 64'd2);
        check("halt_hold",  64'(halted_o), 64'd1);
        tick(1'b1, 1'b0, 32'h1C, 1'b0);
        check("halt_clear", 64'(halted_o), 64'd0);

        // overflow, then full with concurrent pop
        do_reset();
        tick(1'b1, 1'b1, 32'h100, 1'b0);
        for (int i = 0; i < 20; i++) tick(1'b1, 1'b1, 32'h100 + 32'(i * 4), 1'b0);
        check("ovf_count", 64'(count_o),    64'd16);
        check("ovf_flag",  64'(overflow_o), 64'd1);
        check("ovf_drop",  64'(drop_cnt_o), 64'd4);
        check("ovf_head",  64'(rd_pc_o),    64'h100);
        tick(1'b1, 1'b1, 32'h200, 1'b1);
        check("fullpop_count", 64'(count_o),    64'd16);
        check("fullpop_drop",  64'(drop_cnt_o), 64'd4);
        tick(1'b1, 1'b0, 32'h200, 1'b0);
        for (int i = 1; i < 16; i++) drain_check("ovf_drain", 32'h100 + 32'(i * 4));
        drain_check("fullpop_tail", 32'h200);
        check("ovf_empty", 64'(rd_valid_o), 64'd0);

        // wrap-around
        do_reset();
        tick(1'b1, 1'b1, 32'h300, 1'b0);
        for (int i = 0; i < 12; i++) tick(1'b1, 1'b1, 32'h300 + 32'(i * 4), 1'b0);
        tick(1'b1, 1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 10; i++) tick(1'b1, 1'b0, 32'h0, 1'b1);
        tick(1'b1, 1'b1, 32'h400, 1'b0);
        for (int i = 0; i < 12; i++) tick(1'b1, 1'b1, 32'h400 + 32'(i * 4), 1'b0);
        check("wrap_count", 64'(count_o), 64'd14);
        tick(1'b1, 1'b0, 32'h0, 1'b0);
        drain_check("wrap_a", 32'h328);
        drain_check("wrap_b", 32'h32C);
        for (int i = 0; i < 12; i++) drain_check("wrap_c", 32'h400 + 32'(i * 4));

        // enable drop, re-arm with unchanged PC, reset mid-run
        do_reset();
        tick(1'b1, 1'b1, 32'h40, 1'b0);
        tick(1'b1, 1'b1, 32'h40, 1'b0);
        tick(1'b1, 1'b1, 32'h44, 1'b0);
        tick(1'b1, 1'b0, 32'h44, 1'b0);
        check("idle_keep", 64'(count_o), 64'd2);
        tick(1'b1, 1'b1, 32'h44, 1'b0);
        tick(1'b1, 1'b1, 32'h44, 1'b0);
        check("rearm_count", 64'(count_o), 64'd3);
        tick(1'b0, 1'b1, 32'h48, 1'b1);
        check("mrst_count", 64'(count_o),    64'd0);
        check("mrst_valid", 64'(rd_valid_o), 64'd0);
        check("mrst_pc",    64'(rd_pc_o),    64'd0);
        check("mrst_ovf",   64'(overflow_o), 64'd0);
        check("mrst_drop",  64'(drop_cnt_o), 64'd0);
        check("mrst_halt",  64'(halted_o),   64'd0);

        // randomized traffic
        rpc = 32'h0;
        for (int n = 0; n < 4000; n++) begin
            bit r, e, rdy;
            r   = ($urandom_range(0, 499) != 0);
            e   = ($urandom_range(0, 29) != 0);
            rdy = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 9) < 6)
                rpc = 32'($urandom_range(0, 7) * 4);
            rstn       = r;
            en_i       = e;
            pc_i       = rpc;
            instr_i    = $urandom;
            rd_ready_i = rdy;
            @(negedge clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
